// File: rtl/int_seq.sv
// rtl/int_seq.sv - interrupt / reset / BRK entry sequencer
//
// Purpose: runs the seven-state entry sequence (IDLE, T0 dummy, T1-T3 stack
// pushes of PCH/PCL/P, T4/T5 vector fetch) for reset, NMI, IRQ and BRK.
// Optional feature macro: NMI_HIJACK_EN. When it is defined, an NMI that
// becomes pending during T0-T3 of an IRQ/BRK sequence takes over the vector
// fetch.
//
// Ports:
//   clk, rst                  clock, asynchronous active-high reset
//   fetch                     instruction-boundary strobe
//   brk                       BRK opcode flag, sampled with fetch
//   irq_n                     level interrupt request, active low
//   nmi_n                     falling-edge non-maskable interrupt
//   iflag                     status I bit, masks irq_n
//   setreset/setirq/setnmi    T4 pulses selecting the vector kind
//   setstk                    force ADH to the stack page
//   rw                        1 = read, 0 = write
//   pch_dboa/pcl_dboa/p_dboa  drive PCH/PCL/P onto the data bus
//   sp_dec                    decrement the stack pointer
//   adl_vec, vec_oe           vector low-address byte and its enable
//   pcl_ld, pch_ld            latch the data bus into PCL/PCH
//   bflag                     B bit of the pushed P (1 = BRK)
//   seti                      T5 pulse that sets status I
module int_seq (
   input  logic       clk,
   input  logic       rst,
   input  logic       fetch,
   input  logic       brk,
   input  logic       irq_n,
   input  logic       nmi_n,
   input  logic       iflag,
   output logic       setreset,
   output logic       setirq,
   output logic       setnmi,
   output logic       setstk,
   output logic       rw,
   output logic       pch_dboa,
   output logic       pcl_dboa,
   output logic       p_dboa,
   output logic       sp_dec,
   output logic [7:0] adl_vec,
   output logic       vec_oe,
   output logic       pcl_ld,
   output logic       pch_ld,
   output logic       bflag,
   output logic       seti
);

   typedef enum logic [2:0] {
      S_IDLE, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5
   } state_t;

   typedef enum logic [1:0] {
      K_RST, K_NMI, K_IRQ, K_BRK
   } kind_t;

   state_t     state, state_d;
   kind_t      kind, kind_d;
   logic       nmi_q;
   logic       nmi_pend;
   logic       rst_pend;
   logic       nmi_edge;
   logic       nmi_take;
   logic       rst_take;
   logic       nmi_clr;
   logic       hij;
   logic       hij_take;
   logic [7:0] vec_base;

   // nmi_q holds the previous sample so a held-low nmi_n cannot retrigger
   assign nmi_edge = nmi_q & ~nmi_n;
   assign nmi_clr  = nmi_take | hij_take;

   always_comb begin
      state_d  = state;
      kind_d   = kind;
      nmi_take = 1'b0;
      rst_take = 1'b0;
      case (state)
         S_IDLE: begin
            // reset needs no instruction boundary; everything else does
            if (rst_pend) begin
               rst_take = 1'b1;
               kind_d   = K_RST;
               state_d  = S_T0;
            end else if (fetch) begin
               if (nmi_pend) begin
                  nmi_take = 1'b1;
                  kind_d   = K_NMI;
                  state_d  = S_T0;
               end else if (!irq_n && !iflag) begin
                  kind_d  = K_IRQ;
                  state_d = S_T0;
               end else if (brk) begin
                  kind_d  = K_BRK;
                  state_d = S_T0;
               end
            end
         end
         S_T0:    state_d = S_T1;
         S_T1:    state_d = S_T2;
         S_T2:    state_d = S_T3;
         S_T3:    state_d = S_T4;
         S_T4:    state_d = S_T5;
         S_T5:    state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= S_IDLE;
         kind     <= K_RST;
         nmi_q    <= 1'b1;
         nmi_pend <= 1'b0;
         rst_pend <= 1'b1;
      end else begin
         state    <= state_d;
         kind     <= kind_d;
         nmi_q    <= nmi_n;
         // a fresh edge wins over a simultaneous clear
         nmi_pend <= nmi_edge | (nmi_pend & ~nmi_clr);
         if (rst_take) begin
            rst_pend <= 1'b0;
         end
      end
   end

`ifdef NMI_HIJACK_EN
   // decided on the T3->T4 step so both vector cycles agree
   assign hij_take = (state == S_T3) && (kind == K_IRQ || kind == K_BRK) && nmi_pend;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         hij <= 1'b0;
      end else if (hij_take) begin
         hij <= 1'b1;
      end else if (state == S_T5) begin
         hij <= 1'b0;
      end
   end
`else
   assign hij_take = 1'b0;
   assign hij      = 1'b0;
`endif

   always_comb begin
      if (kind == K_NMI || hij) begin
         vec_base = 8'hFA;
      end else if (kind == K_RST) begin
         vec_base = 8'hFC;
      end else begin
         vec_base = 8'hFE;
      end
   end

   always_comb begin
      setreset = 1'b0;
      setirq   = 1'b0;
      setnmi   = 1'b0;
      setstk   = 1'b0;
      rw       = 1'b1;
      pch_dboa = 1'b0;
      pcl_dboa = 1'b0;
      p_dboa   = 1'b0;
      sp_dec   = 1'b0;
      adl_vec  = 8'h00;
      vec_oe   = 1'b0;
      pcl_ld   = 1'b0;
      pch_ld   = 1'b0;
      seti     = 1'b0;
      bflag    = (state != S_IDLE) && (kind == K_BRK);
      case (state)
         S_T1, S_T2, S_T3: begin
            setstk   = 1'b1;
            sp_dec   = 1'b1;
            // reset walks the stack pointer but never writes memory
            rw       = (kind == K_RST);
            pch_dboa = (state == S_T1);
            pcl_dboa = (state == S_T2);
            p_dboa   = (state == S_T3);
         end
         S_T4: begin
            vec_oe   = 1'b1;
            adl_vec  = vec_base;
            pcl_ld   = 1'b1;
            setreset = (kind == K_RST);
            setnmi   = (kind == K_NMI) || hij;
            setirq   = (kind == K_IRQ || kind == K_BRK) && !hij;
         end
         S_T5: begin
            vec_oe   = 1'b1;
            adl_vec  = vec_base + 8'd1;
            pch_ld   = 1'b1;
            seti     = 1'b1;
         end
         default: begin
         end
      endcase
   end

endmodule

// File: tb/tb_int_seq.sv
// tb/tb_int_seq.sv - self-checking bench for int_seq
module tb_int_seq;

   localparam int K_NONE = 0;
   localparam int K_RST  = 1;
   localparam int K_NMI  = 2;
   localparam int K_IRQ  = 3;
   localparam int K_BRK  = 4;

   logic       clk = 1'b0;
   logic       rst;
   logic       fetch, brk, irq_n, nmi_n, iflag;
   logic       setreset, setirq, setnmi, setstk, rw;
   logic       pch_dboa, pcl_dboa, p_dboa, sp_dec;
   logic [7:0] adl_vec;
   logic       vec_oe, pcl_ld, pch_ld, bflag, seti;
   logic [21:0] obs;

   int  checks = 0;
   int  errors = 0;
   bit  nmi_pend_m = 1'b0;

   int_seq dut (
      .clk(clk), .rst(rst), .fetch(fetch), .brk(brk), .irq_n(irq_n),
      .nmi_n(nmi_n), .iflag(iflag), .setreset(setreset), .setirq(setirq),
      .setnmi(setnmi), .setstk(setstk), .rw(rw), .pch_dboa(pch_dboa),
      .pcl_dboa(pcl_dboa), .p_dboa(p_dboa), .sp_dec(sp_dec),
      .adl_vec(adl_vec), .vec_oe(vec_oe), .pcl_ld(pcl_ld), .pch_ld(pch_ld),
      .bflag(bflag), .seti(seti)
   );

   always #5 clk = ~clk;

   assign obs = {setreset, setirq, setnmi, setstk, rw, pch_dboa, pcl_dboa,
                 p_dboa, sp_dec, vec_oe, pcl_ld, pch_ld, bflag, seti, adl_vec};

   // Expected outputs for sequence kind k at step 0..5 (T0..T5); step < 0 is IDLE.
   function automatic logic [21:0] model(int k, int step, bit hj);
      logic sr, si, sn, stk, rw_e, pchd, pcld, pd, spd, voe, pcll, pchl, bf, sti;
      logic [7:0] base, adl;
      bit nv;
      {sr, si, sn, stk, pchd, pcld, pd, spd, voe, pcll, pchl, bf, sti} = '0;
      rw_e = 1'b1;
      adl  = 8'h00;
      if (k != K_NONE && step >= 0) begin
         nv   = (k == K_NMI) || hj;
         base = nv ? 8'hFA : (k == K_RST) ? 8'hFC : 8'hFE;
         bf   = (k == K_BRK);
         if (step >= 1 && step <= 3) begin
            stk  = 1'b1;
            spd  = 1'b1;
            rw_e = (k == K_RST);
            pchd = (step == 1);
            pcld = (step == 2);
            pd   = (step == 3);
         end
         if (step == 4) begin
            voe  = 1'b1;
            adl  = base;
            pcll = 1'b1;
            sr   = (k == K_RST);
            sn   = nv;
            si   = !nv && (k != K_RST);
         end
         if (step == 5) begin
            voe  = 1'b1;
            adl  = base + 8'd1;
            pchl = 1'b1;
            sti  = 1'b1;
         end
      end
      return {sr, si, sn, stk, rw_e, pchd, pcld, pd, spd, voe, pcll, pchl, bf, sti, adl};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(string tag, logic [21:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Assumes the DUT has just entered T0; walks T0..T5 and the return to IDLE.
   // drop >= 0 pulls nmi_n low during that step.
   task automatic run_seq(int k, int drop, string tag, bit garbage);
      bit hj;
      hj = 1'b0;
`ifdef NMI_HIJACK_EN
      hj = (k == K_IRQ || k == K_BRK) && drop >= 0 && drop <= 2;
`endif
      for (int s = 0; s < 6; s++) begin
         check($sformatf("%s_t%0d", tag, s), model(k, s, hj));
         if (s == drop) nmi_n = 1'b0;
         if (garbage) begin
            fetch = 1'($urandom_range(0, 1));
            brk   = 1'($urandom_range(0, 1));
            irq_n = 1'($urandom_range(0, 1));
            iflag = 1'($urandom_range(0, 1));
         end
         tick();
      end
      check({tag, "_idle"}, model(K_NONE, -1, 1'b0));
      if (drop >= 0 && !hj) nmi_pend_m = 1'b1;
   endtask

   // One clock with the current inputs, predicting from priority rules whether
   // a sequence starts and of which kind.
   task automatic boundary(string tag, int drop, bit garbage);
      int k;
      k = K_NONE;
      if (fetch) begin
         if (nmi_pend_m)            k = K_NMI;
         else if (!irq_n && !iflag) k = K_IRQ;
         else if (brk)              k = K_BRK;
      end
      tick();
      if (!garbage) begin
         fetch = 1'b0;
         brk   = 1'b0;
         irq_n = 1'b1;
         iflag = 1'b0;
      end
      if (k == K_NONE) begin
         check({tag, "_noseq"}, model(K_NONE, -1, 1'b0));
      end else begin
         if (k == K_NMI) nmi_pend_m = 1'b0;
         run_seq(k, drop, tag, garbage);
      end
   endtask

   initial begin
      int drop;
      rst   = 1'b1;
      fetch = 1'b0;
      brk   = 1'b0;
      irq_n = 1'b1;
      nmi_n = 1'b1;
      iflag = 1'b0;
      tick();
      check("rst_hold0", model(K_NONE, -1, 1'b0));
      fetch = 1'b1; brk = 1'b1; irq_n = 1'b0;
      tick();
      check("rst_hold1", model(K_NONE, -1, 1'b0));
      fetch = 1'b0; brk = 1'b0; irq_n = 1'b1;

      // release reset: sequence starts without fetch
      rst = 1'b0;
      tick();
      run_seq(K_RST, -1, "reset", 1'b0);

      // IRQ
      irq_n = 1'b0; iflag = 1'b0; fetch = 1'b1;
      boundary("irq", -1, 1'b0);

      // masked IRQ stays idle
      irq_n = 1'b0; iflag = 1'b1; fetch = 1'b1;
      boundary("irq_masked", -1, 1'b0);
      irq_n = 1'b0; iflag = 1'b0; fetch = 1'b0;
      boundary("irq_nofetch", -1, 1'b0);

      // BRK
      brk = 1'b1; fetch = 1'b1;
      boundary("brk", -1, 1'b0);

      // IRQ outranks BRK
      brk = 1'b1; irq_n = 1'b0; fetch = 1'b1;
      boundary("irq_over_brk", -1, 1'b0);

      // NMI held low across two boundaries: exactly one sequence
      nmi_n = 1'b0;
      tick();
      nmi_pend_m = 1'b1;
      fetch = 1'b1; irq_n = 1'b0; brk = 1'b1;
      boundary("nmi", -1, 1'b0);
      fetch = 1'b1;
      boundary("nmi_held1", -1, 1'b0);
      fetch = 1'b1;
      boundary("nmi_held2", -1, 1'b0);
      nmi_n = 1'b1;
      tick();

      // NMI falling during T2 of an IRQ sequence
      irq_n = 1'b0; fetch = 1'b1;
      boundary("irq_nmi_t2", 2, 1'b0);
      nmi_n = 1'b1;
      fetch = 1'b1;
      boundary("after_hijack", -1, 1'b0);

      // NMI falling during T1 of BRK keeps bflag
      brk = 1'b1; fetch = 1'b1;
      boundary("brk_nmi_t1", 1, 1'b0);
      nmi_n = 1'b1;
      fetch = 1'b1;
      boundary("after_brk_nmi", -1, 1'b0);

      // reset aborting a sequence mid-flight
      brk = 1'b1; fetch = 1'b1;
      tick();
      fetch = 1'b0; brk = 1'b0;
      check("abort_t0", model(K_BRK, 0, 1'b0));
      tick();
      tick();
      check("abort_t2", model(K_BRK, 2, 1'b0));
      rst = 1'b1;
      #1;
      check("abort_async", model(K_NONE, -1, 1'b0));
      tick();
      check("abort_hold", model(K_NONE, -1, 1'b0));
      rst = 1'b0;
      nmi_pend_m = 1'b0;
      tick();
      run_seq(K_RST, -1, "abort_reset", 1'b0);

      // randomized boundaries with noise during sequences
      for (int i = 0; i < 80; i++) begin
         nmi_n = 1'b1;
         fetch = 1'($urandom_range(0, 1));
         brk   = 1'($urandom_range(0, 1));
         irq_n = 1'($urandom_range(0, 1));
         iflag = 1'($urandom_range(0, 1));
         drop  = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 5)) : -1;
         boundary($sformatf("rnd%0d", i), drop, 1'b1);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/int_seq.md
INT_SEQ -- requirements
Module: int_seq

Interface
REQ-001 SHALL: clk  in  1  single clock; all state changes on posedge clk.
REQ-002 SHALL: rst  in  1  asynchronous, active-high reset.
REQ-003 SHALL: fetch  in  1  instruction-boundary strobe; events are taken only in a cycle where fetch=1.
REQ-004 SHALL: brk  in  1  decoder flags a BRK opcode; sampled with fetch.
REQ-005 SHALL: irq_n  in  1  level-sensitive interrupt request, active low.
REQ-006 SHALL: nmi_n  in  1  falling-edge-sensitive non-maskable interrupt.
REQ-007 SHALL: iflag  in  1  status I bit; 1 masks irq_n.
REQ-008 SHALL: setreset  out  1  one-cycle pulse; PC-high loads 0xFF for the reset vector.
REQ-009 SHALL: setirq  out  1  one-cycle pulse; PC-high loads 0xFF for the IRQ/BRK vector.
REQ-010 SHALL: setnmi  out  1  one-cycle pulse; PC-high loads 0xFF for the NMI vector.
REQ-011 SHALL: setstk  out  1  force ADH=0x01 (stack page).
REQ-012 SHALL: rw  out  1  1=read, 0=write.
REQ-013 SHALL: pch_dboa, pcl_dboa, p_dboa  out  1 each  drive PCH, PCL or P onto the data bus.
REQ-014 SHALL: sp_dec  out  1  decrement stack pointer this cycle.
REQ-015 SHALL: adl_vec  out  8  vector low-address byte.
REQ-016 SHALL: vec_oe  out  1  adl_vec drives ADL.
REQ-017 SHALL: pcl_ld, pch_ld  out  1 each  latch data bus into PCL or PCH.
REQ-018 SHALL: bflag  out  1  B bit value for the pushed P (1 = BRK, 0 = hardware event).
REQ-019 SHALL: seti  out  1  one-cycle pulse that sets status I.

Function
REQ-020 SHALL use states IDLE, T0 (dummy), T1 (push PCH), T2 (push PCL), T3 (push P), T4 (vector low), T5 (vector high), advancing one state per clk; T5 returns to IDLE.
REQ-021 SHALL leave IDLE for T0 in the cycle after fetch=1 with a pending event; it SHALL otherwise remain in IDLE.
REQ-022 SHALL select by priority reset > NMI > IRQ (irq_n=0 and iflag=0) > BRK; the selected kind is latched at T0 entry.
REQ-023 SHALL set an NMI pending flag on a sampled 1->0 transition of nmi_n and clear it on T0 entry of an NMI sequence; a held-low nmi_n SHALL NOT retrigger.
REQ-024 SHALL assert setstk and sp_dec in T1-T3, with pch_dboa in T1, pcl_dboa in T2, p_dboa in T3; rw=0 in T1-T3 except for reset, where rw stays 1 (pushes suppressed, sp_dec still asserted).
REQ-025 SHALL output adl_vec=0xFA for NMI, 0xFC for reset, 0xFE for IRQ/BRK in T4, and that value +1 in T5, with vec_oe=1 in T4-T5.
REQ-026 SHALL pulse the matching setreset/setirq/setnmi and pcl_ld in T4, and pch_ld and seti in T5.
REQ-027 SHALL hold bflag=1 for the whole of a BRK sequence and 0 otherwise.
REQ-028 SHALL ignore fetch, irq_n and brk outside IDLE; NMI edges arriving in that window SHALL still be latched.
REQ-029 SHALL drive all outputs to 0, except rw=1, in IDLE.

Reset
REQ-030 SHALL, while rst=1, force IDLE, clear NMI pending, set reset pending, and hold all outputs at their IDLE values; rst mid-sequence SHALL abort it.
REQ-031 SHALL begin the reset sequence (T0) on the first clk after rst deasserts, without requiring fetch.

Configuration
REQ-032 SHALL, with NMI_HIJACK_EN defined, let an NMI that becomes pending during T0-T3 of an IRQ/BRK sequence redirect T4/T5 to 0xFA/0xFB, pulse setnmi instead of setirq, clear NMI pending, and keep bflag unchanged.
REQ-033 SHALL, without NMI_HIJACK_EN, leave such an NMI pending for the next fetch boundary.

Verification
REQ-034 SHALL cover: release rst -> T0..T5 with rw=1 throughout, sp_dec three cycles, adl_vec 0xFC then 0xFD, setreset in T4.
REQ-035 SHALL cover: irq_n=0, iflag=0, fetch=1 -> writes PCH/PCL/P in T1-T3, adl_vec 0xFE/0xFF, bflag=0, seti in T5.
REQ-036 SHALL cover: irq_n=0 with iflag=1, fetch=1 -> stays IDLE; brk=1 with fetch=1 -> sequence with bflag=1 and vector 0xFE.
REQ-037 SHALL cover: nmi_n falls and stays low across two boundaries -> exactly one sequence with vector 0xFA, setnmi pulse.
REQ-038 SHALL cover: nmi_n falls in T2 of an IRQ sequence -> 0xFA/0xFB with NMI_HIJACK_EN; 0xFE/0xFF then a second NMI sequence without it.
